pcie_mim_init_s6: RTL and testbench
===================================

Name: pcie_mim_init_s6

Overview:
- Sits between the Spartan-6 PCIe hard block MIM ports and the TX/RX BRAM top, on both the TX and RX buffers.
- After every reset it zero-fills both buffers, then reads them back to check the fill. Only then does it hand the MIM ports to the core, with a zero-latency pass-through.
- `init_done` gates the core's user reset; `init_error` and `err_count` report BRAM read-back faults to the MicroBlaze.

Parameters:
- `CLEAR_WORDS`, 4096: words cleared and verified per buffer, starting at address 0; legal range 1..4096.
- `READ_LATENCY`, 3: cycles from a read issue (`ren`=1 with `raddr`) to valid `rdata`. Equals RAM_RADDR_LATENCY + RAM_RDATA_LATENCY of the attached BRAMs.
- `VERIFY_EN`, 1: 1 runs the read-back pass; 0 skips it, so init ends after the clear pass.

Ports:
- `user_clk_i`  in  1  user clock; all logic is on its rising edge.
- `reset_i`  in  1  synchronous active-high reset.
- `core_tx_wen`, `core_tx_ren`, `core_tx_rce`  in  1 each  core TX MIM controls.
- `core_tx_waddr`, `core_tx_raddr`  in  12 each  core TX MIM addresses.
- `core_tx_wdata`  in  36  core TX write data.
- `core_tx_rdata`  out  36  TX read data returned to the core.
- `core_rx_*`  (same set and widths as `core_tx_*`)  core RX MIM port.
- `mim_tx_wen`, `mim_tx_ren`, `mim_tx_rce`  out  1 each  to the BRAM top.
- `mim_tx_waddr`, `mim_tx_raddr`  out  12 each  to the BRAM top.
- `mim_tx_wdata`  out  36  to the BRAM top.
- `mim_tx_rdata`  in  36  from the BRAM top.
- `mim_rx_*`  (same set and widths as `mim_tx_*`)  RX side to/from the BRAM top.
- `init_done`  out  1  high once init is complete; stays high until the next reset.
- `init_error`  out  1  sticky; a verify mismatch has occurred since the last reset.
- `err_count`  out  16  number of mismatching words, summed over TX and RX; saturates at 0xFFFF.

Behaviour:
- **Reset** (`reset_i`=1 at a clock edge):
  - State goes to CLEAR and the address counter to 0.
  - `init_done`=0, `init_error`=0, `err_count`=0, the read-valid pipeline is flushed.
  - While `reset_i` is high, all `mim_*` controls are 0, and all `mim_*` addresses and data are 0.
  - Reset mid-operation, in any state including DONE, restarts init from address 0 on the next cycle.
- **State machine:** CLEAR -> VERIFY -> DRAIN -> DONE. With `VERIFY_EN`=0 the sequence is CLEAR -> DONE.
- **Cycle numbering:** cycle 0 is the first cycle after `reset_i` falls. N = `CLEAR_WORDS`, L = `READ_LATENCY`.
- **CLEAR**, cycles 0..N-1, both buffers in parallel:
  - `mim_*_wen`=1, `mim_*_waddr`=counter, `mim_*_wdata`=0.
  - `ren`=0, `rce`=0.
  - Counter increments each cycle; on reaching N-1 it wraps to 0 and the state advances.
- **VERIFY**, cycles N..2N-1:
  - `wen`=0, `mim_*_ren`=1, `mim_*_rce`=1, `mim_*_raddr`=counter.
  - A 1-bit valid is pushed into an L-deep shift register.
- **DRAIN**, cycles 2N..2N+L-1:
  - `ren`=0, `rce` held at 1 so the in-flight data completes.
  - The state advances when the last valid exits the pipe.
- **Compare:**
  - When the pipe output is valid, each port's `mim_*_rdata` is compared against 36'h0.
  - `err_count` += number of mismatching ports that cycle (0, 1 or 2), saturating at 0xFFFF; saturation never wraps.
  - Any mismatch sets `init_error`, which stays set until reset.
- **DONE:**
  - `init_done`=1 from cycle 2N+L (or cycle N when `VERIFY_EN`=0), registered.
  - All `mim_*` outputs equal the corresponding `core_*` inputs combinationally, with 0 added latency.
  - Verification never runs again until the next reset.
- **Core inputs before DONE:** ignored entirely; no core write may reach the BRAM.
- **Read data:** `core_*_rdata` = `mim_*_rdata` at all times, pure pass-through. Before DONE its contents are don't-care to the core.
- **Widths and ranges:**
  - The counter is 13 bits wide so that `CLEAR_WORDS`=4096 terminates correctly.
  - `mim_*_waddr` and `mim_*_raddr` use counter[11:0].
  - `READ_LATENCY` legal range is 1..8.

Test Plan:
- N=16, L=3, `VERIFY_EN`=1, BRAM model zeroed, reset released.
  - Expect `mim_tx_wen`=`mim_rx_wen`=1 on cycles 0..15 with waddr 0..15 and wdata 0, then ren=1 on cycles 16..31 with raddr 0..15.
  - Expect `init_done`=1 from cycle 35, `err_count`=0, `init_error`=0.
- Same setup, with the RX model forcing address 5 to read 36'h1 and TX address 9 to read 36'h8_0000_0000.
  - Expect `err_count`=2, `init_error`=1, `init_done` still rising at cycle 35.
- Core toggles `core_tx_wen`=1, waddr=0x123, wdata=0xABCDE during CLEAR.
  - Expect no `mim_tx` write to 0x123.
  - After DONE, the same stimulus appears on `mim_tx_*` in the same cycle.
- Assert `reset_i` for 1 cycle at cycle 20 (during VERIFY) after having injected 1 error.
  - Expect `err_count`=0, `init_error`=0, `init_done`=0.
  - Expect CLEAR restarting at address 0 the cycle after reset falls, and `init_done` at 35 cycles after that.
- N=4096, L=3, `VERIFY_EN`=0.
  - Expect exactly 4096 writes covering addresses 0x000..0xFFF, no reads, and `init_done`=1 at cycle 4096.
- Force every read to mismatch on both ports, with N=4096 and 1 extra re-init via repeated reset omitted.
  - Expect `err_count`=8192 (0x2000).
  - Separately, preload `err_count` to 0xFFFE via force, then inject 2 mismatches in one cycle: expect 0xFFFF with no wrap.

Source files
------------

// File: rtl/pcie_mim_init_s6.sv
// Post-reset BRAM initialiser for the Spartan-6 PCIe TX/RX MIM ports: zero-fill, optional
// read-back check, then a zero-latency pass-through of the core's MIM ports.
module pcie_mim_init_s6 #(
  parameter int unsigned CLEAR_WORDS  = 4096,
  parameter int unsigned READ_LATENCY = 3,
  parameter bit          VERIFY_EN    = 1'b1
) (
  input  logic        user_clk_i,
  input  logic        reset_i,
  input  logic        core_tx_wen,
  input  logic        core_tx_ren,
  input  logic        core_tx_rce,
  input  logic [11:0] core_tx_waddr,
  input  logic [11:0] core_tx_raddr,
  input  logic [35:0] core_tx_wdata,
  output logic [35:0] core_tx_rdata,
  input  logic        core_rx_wen,
  input  logic        core_rx_ren,
  input  logic        core_rx_rce,
  input  logic [11:0] core_rx_waddr,
  input  logic [11:0] core_rx_raddr,
  input  logic [35:0] core_rx_wdata,
  output logic [35:0] core_rx_rdata,
  output logic        mim_tx_wen,
  output logic        mim_tx_ren,
  output logic        mim_tx_rce,
  output logic [11:0] mim_tx_waddr,
  output logic [11:0] mim_tx_raddr,
  output logic [35:0] mim_tx_wdata,
  input  logic [35:0] mim_tx_rdata,
  output logic        mim_rx_wen,
  output logic        mim_rx_ren,
  output logic        mim_rx_rce,
  output logic [11:0] mim_rx_waddr,
  output logic [11:0] mim_rx_raddr,
  output logic [35:0] mim_rx_wdata,
  input  logic [35:0] mim_rx_rdata,
  output logic        init_done,
  output logic        init_error,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {StClear, StVerify, StDrain, StDone} state_e;

  // 13-bit counter so CLEAR_WORDS = 4096 still has a representable last index.
  localparam logic [12:0] LastWord = 13'(CLEAR_WORDS - 1);

  state_e                  state_q;
  logic [12:0]             cnt_q;
  logic [READ_LATENCY-1:0] pipe_q;
  logic [READ_LATENCY-1:0] pipe_d;
  logic                    init_done_q;
  logic                    init_error_q;
  logic [15:0]             err_count_q;

  logic        cnt_last;
  logic        cmp_valid;
  logic        tx_mis;
  logic        rx_mis;
  logic [1:0]  n_mis;
  logic [16:0] err_sum;
  logic [15:0] err_sat;

  always_comb begin
    cnt_last  = (cnt_q == LastWord);
    pipe_d    = pipe_q << 1;
    pipe_d[0] = (state_q == StVerify);
    cmp_valid = pipe_q[READ_LATENCY-1];
    tx_mis    = cmp_valid && (mim_tx_rdata != 36'h0);
    rx_mis    = cmp_valid && (mim_rx_rdata != 36'h0);
    n_mis     = {1'b0, tx_mis} + {1'b0, rx_mis};
    err_sum   = {1'b0, err_count_q} + {15'd0, n_mis};
    err_sat   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge user_clk_i) begin
    if (reset_i) begin
      state_q      <= StClear;
      cnt_q        <= '0;
      pipe_q       <= '0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      if (n_mis != 2'd0) begin
        init_error_q <= 1'b1;
        err_count_q  <= err_sat;
      end
      unique case (state_q)
        StClear: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (VERIFY_EN) begin
              state_q <= StVerify;
            end else begin
              state_q     <= StDone;
              init_done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        StVerify: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        StDrain: begin
          // Leave once the final read's valid bit is the only one left in the pipe.
          if (pipe_d == '0) begin
            state_q     <= StDone;
            init_done_q <= 1'b1;
          end
        end
        StDone: ;
        default: state_q <= StClear;
      endcase
    end
  end

  always_comb begin
    mim_tx_wen   = 1'b0;
    mim_tx_ren   = 1'b0;
    mim_tx_rce   = 1'b0;
    mim_tx_waddr = '0;
    mim_tx_raddr = '0;
    mim_tx_wdata = '0;
    mim_rx_wen   = 1'b0;
    mim_rx_ren   = 1'b0;
    mim_rx_rce   = 1'b0;
    mim_rx_waddr = '0;
    mim_rx_raddr = '0;
    mim_rx_wdata = '0;
    if (!reset_i) begin
      unique case (state_q)
        StClear: begin
          mim_tx_wen   = 1'b1;
          mim_rx_wen   = 1'b1;
          mim_tx_waddr = cnt_q[11:0];
          mim_rx_waddr = cnt_q[11:0];
        end
        StVerify: begin
          mim_tx_ren   = 1'b1;
          mim_rx_ren   = 1'b1;
          mim_tx_rce   = 1'b1;
          mim_rx_rce   = 1'b1;
          mim_tx_raddr = cnt_q[11:0];
          mim_rx_raddr = cnt_q[11:0];
        end
        StDrain: begin
          mim_tx_rce = 1'b1;
          mim_rx_rce = 1'b1;
        end
        StDone: begin
          mim_tx_wen   = core_tx_wen;
          mim_tx_ren   = core_tx_ren;
          mim_tx_rce   = core_tx_rce;
          mim_tx_waddr = core_tx_waddr;
          mim_tx_raddr = core_tx_raddr;
          mim_tx_wdata = core_tx_wdata;
          mim_rx_wen   = core_rx_wen;
          mim_rx_ren   = core_rx_ren;
          mim_rx_rce   = core_rx_rce;
          mim_rx_waddr = core_rx_waddr;
          mim_rx_raddr = core_rx_raddr;
          mim_rx_wdata = core_rx_wdata;
        end
        default: ;
      endcase
    end
  end

  assign core_tx_rdata = mim_tx_rdata;
  assign core_rx_rdata = mim_rx_rdata;
  assign init_done     = init_done_q;
  assign init_error    = init_error_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_pcie_mim_init_s6.sv
// Directed bench: a small N=16 instance with a 3-cycle BRAM model, plus two N=4096 instances.
module tb_pcie_mim_init_s6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic big_rst = 1'b1;

  logic        core_tx_wen, core_tx_ren, core_tx_rce;
  logic [11:0] core_tx_waddr, core_tx_raddr;
  logic [35:0] core_tx_wdata, core_tx_rdata;
  logic        core_rx_wen, core_rx_ren, core_rx_rce;
  logic [11:0] core_rx_waddr, core_rx_raddr;
  logic [35:0] core_rx_wdata, core_rx_rdata;
  logic        mim_tx_wen, mim_tx_ren, mim_tx_rce;
  logic [11:0] mim_tx_waddr, mim_tx_raddr;
  logic [35:0] mim_tx_wdata;
  logic        mim_rx_wen, mim_rx_ren, mim_rx_rce;
  logic [11:0] mim_rx_waddr, mim_rx_raddr;
  logic [35:0] mim_rx_wdata;
  logic        init_done, init_error;
  logic [15:0] err_count;

  pcie_mim_init_s6 #(.CLEAR_WORDS(16), .READ_LATENCY(3), .VERIFY_EN(1'b1)) dut (
    .user_clk_i(clk), .reset_i(rst),
    .core_tx_wen(core_tx_wen), .core_tx_ren(core_tx_ren), .core_tx_rce(core_tx_rce),
    .core_tx_waddr(core_tx_waddr), .core_tx_raddr(core_tx_raddr),
    .core_tx_wdata(core_tx_wdata), .core_tx_rdata(core_tx_rdata),
    .core_rx_wen(core_rx_wen), .core_rx_ren(core_rx_ren), .core_rx_rce(core_rx_rce),
    .core_rx_waddr(core_rx_waddr), .core_rx_raddr(core_rx_raddr),
    .core_rx_wdata(core_rx_wdata), .core_rx_rdata(core_rx_rdata),
    .mim_tx_wen(mim_tx_wen), .mim_tx_ren(mim_tx_ren), .mim_tx_rce(mim_tx_rce),
    .mim_tx_waddr(mim_tx_waddr), .mim_tx_raddr(mim_tx_raddr),
    .mim_tx_wdata(mim_tx_wdata), .mim_tx_rdata(tx_p3),
    .mim_rx_wen(mim_rx_wen), .mim_rx_ren(mim_rx_ren), .mim_rx_rce(mim_rx_rce),
    .mim_rx_waddr(mim_rx_waddr), .mim_rx_raddr(mim_rx_raddr),
    .mim_rx_wdata(mim_rx_wdata), .mim_rx_rdata(rx_p3),
    .init_done(init_done), .init_error(init_error), .err_count(err_count)
  );

  // BRAM model: unwritten words hold non-zero garbage, reads return data 3 cycles after issue.
  logic [35:0] tx_mem [4096] = '{default: 36'hF_FFFF_FFFF};
  logic [35:0] rx_mem [4096] = '{default: 36'hF_FFFF_FFFF};
  logic [35:0] tx_p1 = '0, tx_p2 = '0, tx_p3 = '0;
  logic [35:0] rx_p1 = '0, rx_p2 = '0, rx_p3 = '0;
  int          tx_lo = -1, tx_hi = -1, rx_lo = -1, rx_hi = -1;
  logic [35:0] tx_val = '0, rx_val = '0;
  int          bad123 = 0;

  always @(posedge clk) begin
    if (mim_tx_wen) tx_mem[mim_tx_waddr] <= mim_tx_wdata;
    if (mim_rx_wen) rx_mem[mim_rx_waddr] <= mim_rx_wdata;
    if (mim_tx_ren)
      tx_p1 <= (int'(mim_tx_raddr) >= tx_lo && int'(mim_tx_raddr) <= tx_hi) ? tx_val
                                                                             : tx_mem[mim_tx_raddr];
    if (mim_rx_ren)
      rx_p1 <= (int'(mim_rx_raddr) >= rx_lo && int'(mim_rx_raddr) <= rx_hi) ? rx_val
                                                                             : rx_mem[mim_rx_raddr];
    tx_p2 <= tx_p1;
    tx_p3 <= tx_p2;
    rx_p2 <= rx_p1;
    rx_p3 <= rx_p2;
    if (mim_tx_wen && mim_tx_waddr == 12'h123 && !init_done) bad123 <= bad123 + 1;
  end

  // Large instances: shared tied-off core inputs, separate outputs.
  logic        z1 = 1'b0;
  logic [11:0] z12 = '0;
  logic [35:0] z36 = '0;
  logic [35:0] e_rdata = 36'h1;
  logic        b_tx_wen, b_tx_ren, b_tx_rce, b_rx_wen, b_rx_ren, b_rx_rce, b_done, b_error;
  logic [11:0] b_tx_waddr, b_tx_raddr, b_rx_waddr, b_rx_raddr;
  logic [35:0] b_tx_wdata, b_rx_wdata, b_tx_rdata, b_rx_rdata;
  logic [15:0] b_err;
  logic        e_tx_wen, e_tx_ren, e_tx_rce, e_rx_wen, e_rx_ren, e_rx_rce, e_done, e_error;
  logic [11:0] e_tx_waddr, e_tx_raddr, e_rx_waddr, e_rx_raddr;
  logic [35:0] e_tx_wdata, e_rx_wdata, e_tx_rdata, e_rx_rdata;
  logic [15:0] e_err;

  pcie_mim_init_s6 #(.CLEAR_WORDS(4096), .READ_LATENCY(3), .VERIFY_EN(1'b0)) dut_big (
    .user_clk_i(clk), .reset_i(big_rst),
    .core_tx_wen(z1), .core_tx_ren(z1), .core_tx_rce(z1), .core_tx_waddr(z12),
    .core_tx_raddr(z12), .core_tx_wdata(z36), .core_tx_rdata(b_tx_rdata),
    .core_rx_wen(z1), .core_rx_ren(z1), .core_rx_rce(z1), .core_rx_waddr(z12),
    .core_rx_raddr(z12), .core_rx_wdata(z36), .core_rx_rdata(b_rx_rdata),
    .mim_tx_wen(b_tx_wen), .mim_tx_ren(b_tx_ren), .mim_tx_rce(b_tx_rce),
    .mim_tx_waddr(b_tx_waddr), .mim_tx_raddr(b_tx_raddr), .mim_tx_wdata(b_tx_wdata),
    .mim_tx_rdata(z36),
    .mim_rx_wen(b_rx_wen), .mim_rx_ren(b_rx_ren), .mim_rx_rce(b_rx_rce),
    .mim_rx_waddr(b_rx_waddr), .mim_rx_raddr(b_rx_raddr), .mim_rx_wdata(b_rx_wdata),
    .mim_rx_rdata(z36),
    .init_done(b_done), .init_error(b_error), .err_count(b_err)
  );

  pcie_mim_init_s6 #(.CLEAR_WORDS(4096), .READ_LATENCY(3), .VERIFY_EN(1'b1)) dut_err (
    .user_clk_i(clk), .reset_i(big_rst),
    .core_tx_wen(z1), .core_tx_ren(z1), .core_tx_rce(z1), .core_tx_waddr(z12),
    .core_tx_raddr(z12), .core_tx_wdata(z36), .core_tx_rdata(e_tx_rdata),
    .core_rx_wen(z1), .core_rx_ren(z1), .core_rx_rce(z1), .core_rx_waddr(z12),
    .core_rx_raddr(z12), .core_rx_wdata(z36), .core_rx_rdata(e_rx_rdata),
    .mim_tx_wen(e_tx_wen), .mim_tx_ren(e_tx_ren), .mim_tx_rce(e_tx_rce),
    .mim_tx_waddr(e_tx_waddr), .mim_tx_raddr(e_tx_raddr), .mim_tx_wdata(e_tx_wdata),
    .mim_tx_rdata(e_rdata),
    .mim_rx_wen(e_rx_wen), .mim_rx_ren(e_rx_ren), .mim_rx_rce(e_rx_rce),
    .mim_rx_waddr(e_rx_waddr), .mim_rx_raddr(e_rx_raddr), .mim_rx_wdata(e_rx_wdata),
    .mim_rx_rdata(e_rdata),
    .init_done(e_done), .init_error(e_error), .err_count(e_err)
  );

  int checks = 0;
  int errors = 0;
  int cur = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the negedge inside cycle 'target' (cycle 0 follows the reset edge).
  task automatic wait_cycle(input int target);
    while (cur < target) begin
      @(negedge clk);
      cur++;
    end
  endtask

  // Called mid-cycle: raise reset, confirm the MIM side is quiet, release after one edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_quiet_tx", 64'(|{mim_tx_wen, mim_tx_ren, mim_tx_rce, mim_tx_waddr,
                                mim_tx_raddr, mim_tx_wdata}), 64'd0);
    check("rst_quiet_rx", 64'(|{mim_rx_wen, mim_rx_ren, mim_rx_rce, mim_rx_waddr,
                                mim_rx_raddr, mim_rx_wdata}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cur = -1;
  endtask

  typedef struct {
    int          cyc;
    logic        wen;
    logic        rx_wen;
    logic [11:0] waddr;
    logic [35:0] wdata;
    logic        ren;
    logic        rce;
    logic [11:0] raddr;
    logic        done;
  } vec_t;

  vec_t vec [11];
  bit   [4095:0] seen;
  int   b_wr_tx, b_wr_rx, b_rd, b_done_cyc, e_done_cyc;

  initial begin
    vec[0]  = '{0,  1'b1, 1'b1, 12'd0,   36'h0,     1'b0, 1'b0, 12'd0,  1'b0};
    vec[1]  = '{1,  1'b1, 1'b1, 12'd1,   36'h0,     1'b0, 1'b0, 12'd0,  1'b0};
    vec[2]  = '{7,  1'b1, 1'b1, 12'd7,   36'h0,     1'b0, 1'b0, 12'd0,  1'b0};
    vec[3]  = '{15, 1'b1, 1'b1, 12'd15,  36'h0,     1'b0, 1'b0, 12'd0,  1'b0};
    vec[4]  = '{16, 1'b0, 1'b0, 12'd0,   36'h0,     1'b1, 1'b1, 12'd0,  1'b0};
    vec[5]  = '{17, 1'b0, 1'b0, 12'd0,   36'h0,     1'b1, 1'b1, 12'd1,  1'b0};
    vec[6]  = '{31, 1'b0, 1'b0, 12'd0,   36'h0,     1'b1, 1'b1, 12'd15, 1'b0};
    vec[7]  = '{32, 1'b0, 1'b0, 12'd0,   36'h0,     1'b0, 1'b1, 12'd0,  1'b0};
    vec[8]  = '{34, 1'b0, 1'b0, 12'd0,   36'h0,     1'b0, 1'b1, 12'd0,  1'b0};
    vec[9]  = '{35, 1'b1, 1'b0, 12'h123, 36'hABCDE, 1'b0, 1'b0, 12'd0,  1'b1};
    vec[10] = '{36, 1'b1, 1'b0, 12'h123, 36'hABCDE, 1'b0, 1'b0, 12'd0,  1'b1};

    // Core keeps trying to write 0x123 the whole time; it must only land after DONE.
    core_tx_wen = 1'b1; core_tx_ren = 1'b0; core_tx_rce = 1'b0;
    core_tx_waddr = 12'h123; core_tx_raddr = '0; core_tx_wdata = 36'hABCDE;
    core_rx_wen = 1'b0; core_rx_ren = 1'b0; core_rx_rce = 1'b0;
    core_rx_waddr = '0; core_rx_raddr = '0; core_rx_wdata = '0;

    // Run 1: clean init, table-driven.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      wait_cycle(vec[i].cyc);
      check($sformatf("c%0d wen", vec[i].cyc), 64'({mim_tx_wen, mim_rx_wen}),
            64'({vec[i].wen, vec[i].rx_wen}));
      if (vec[i].wen) begin
        check($sformatf("c%0d tx_waddr", vec[i].cyc), 64'(mim_tx_waddr), 64'(vec[i].waddr));
        check($sformatf("c%0d tx_wdata", vec[i].cyc), 64'(mim_tx_wdata), 64'(vec[i].wdata));
      end
      if (vec[i].rx_wen) begin
        check($sformatf("c%0d rx_waddr", vec[i].cyc), 64'(mim_rx_waddr), 64'(vec[i].waddr));
        check($sformatf("c%0d rx_wdata", vec[i].cyc), 64'(mim_rx_wdata), 64'h0);
      end
      check($sformatf("c%0d ren", vec[i].cyc), 64'({mim_tx_ren, mim_rx_ren}),
            64'({2{vec[i].ren}}));
      check($sformatf("c%0d rce", vec[i].cyc), 64'({mim_tx_rce, mim_rx_rce}),
            64'({2{vec[i].rce}}));
      if (vec[i].ren)
        check($sformatf("c%0d raddr", vec[i].cyc), 64'({mim_tx_raddr, mim_rx_raddr}),
              64'({vec[i].raddr, vec[i].raddr}));
      check($sformatf("c%0d done", vec[i].cyc), 64'(init_done), 64'(vec[i].done));
    end
    check("run1 err_count", 64'(err_count), 64'd0);
    check("run1 init_error", 64'(init_error), 64'd0);
    check("run1 no early 0x123 write", 64'(bad123), 64'd0);
    check("tx rdata pass", 64'(core_tx_rdata), 64'(tx_p3));

    // Pass-through in DONE is combinational.
    core_tx_ren = 1'b1; core_tx_rce = 1'b1; core_tx_raddr = 12'h456;
    core_tx_waddr = 12'h7FF; core_tx_wdata = 36'h9_8765_4321;
    core_rx_wen = 1'b1; core_rx_rce = 1'b1; core_rx_waddr = 12'hABC; core_rx_wdata = 36'h5A5;
    #1;
    check("pass tx", 64'({mim_tx_wen, mim_tx_ren, mim_tx_rce, mim_tx_raddr, mim_tx_waddr}),
          64'({3'b111, 12'h456, 12'h7FF}));
    check("pass tx wdata", 64'(mim_tx_wdata), 64'h9_8765_4321);
    check("pass rx", 64'({mim_rx_wen, mim_rx_ren, mim_rx_rce, mim_rx_waddr, mim_rx_wdata}),
          64'({3'b101, 12'hABC, 36'h5A5}));

    // Run 2: one mismatch per port.
    rx_lo = 5; rx_hi = 5; rx_val = 36'h1;
    tx_lo = 9; tx_hi = 9; tx_val = 36'h8_0000_0000;
    do_reset();
    core_tx_wen = 1'b0; core_tx_ren = 1'b0; core_tx_rce = 1'b0;
    core_rx_wen = 1'b0; core_rx_rce = 1'b0;
    wait_cycle(24);
    check("run2 c24 err", 64'(err_count), 64'd0);
    wait_cycle(25);
    check("run2 c25 err", 64'(err_count), 64'd1);
    check("run2 c25 init_error", 64'(init_error), 64'd1);
    wait_cycle(29);
    check("run2 c29 err", 64'(err_count), 64'd2);
    wait_cycle(34);
    check("run2 c34 done", 64'(init_done), 64'd0);
    wait_cycle(35);
    check("run2 c35 done", 64'(init_done), 64'd1);
    check("run2 err_count", 64'(err_count), 64'd2);
    check("run2 init_error", 64'(init_error), 64'd1);

    // Run 3: error seen, then reset during VERIFY at cycle 20.
    rx_lo = -1; rx_hi = -1;
    tx_lo = 0; tx_hi = 0; tx_val = 36'h5;
    wait_cycle(36);
    do_reset();
    wait_cycle(20);
    check("run3 c20 err", 64'(err_count), 64'd1);
    check("run3 c20 init_error", 64'(init_error), 64'd1);
    tx_lo = -1; tx_hi = -1;
    do_reset();
    wait_cycle(0);
    check("run3 restart err", 64'(err_count), 64'd0);
    check("run3 restart init_error", 64'(init_error), 64'd0);
    check("run3 restart done", 64'(init_done), 64'd0);
    check("run3 restart clear", 64'({mim_tx_wen, mim_tx_waddr}), 64'({1'b1, 12'd0}));
    wait_cycle(34);
    check("run3 c34 done", 64'(init_done), 64'd0);
    wait_cycle(35);
    check("run3 c35 done", 64'(init_done), 64'd1);
    check("run3 err_count", 64'(err_count), 64'd0);

    // Run 4: saturation from 0xFFFE with double mismatches at addresses 3 and 4.
    tx_lo = 3; tx_hi = 4; tx_val = 36'hF;
    rx_lo = 3; rx_hi = 4; rx_val = 36'hF;
    do_reset();
    wait_cycle(21);
    force dut.err_count_q = 16'hFFFE;
    #1;
    release dut.err_count_q;
    wait_cycle(22);
    check("sat c22", 64'(err_count), 64'hFFFE);
    wait_cycle(23);
    check("sat c23", 64'(err_count), 64'hFFFF);
    wait_cycle(24);
    check("sat c24 no wrap", 64'(err_count), 64'hFFFF);
    wait_cycle(35);
    check("sat end", 64'(err_count), 64'hFFFF);
    check("sat init_error", 64'(init_error), 64'd1);
    tx_lo = -1; tx_hi = -1; rx_lo = -1; rx_hi = -1;

    // Large instances run together.
    seen = '0;
    b_wr_tx = 0; b_wr_rx = 0; b_rd = 0; b_done_cyc = -1; e_done_cyc = -1;
    @(posedge clk);
    #1 big_rst = 1'b0;
    for (int k = 0; k < 8200; k++) begin
      @(negedge clk);
      if (b_tx_wen && !b_done) begin
        b_wr_tx++;
        seen[b_tx_waddr] = 1'b1;
      end
      if (b_rx_wen && !b_done) b_wr_rx++;
      if (b_tx_ren || b_rx_ren) b_rd++;
      if (b_done && b_done_cyc < 0) b_done_cyc = k;
      if (e_done && e_done_cyc < 0) e_done_cyc = k;
    end
    check("big tx writes", 64'(b_wr_tx), 64'd4096);
    check("big rx writes", 64'(b_wr_rx), 64'd4096);
    check("big distinct addrs", 64'($countones(seen)), 64'd4096);
    check("big reads", 64'(b_rd), 64'd0);
    check("big done cycle", 64'(b_done_cyc), 64'd4096);
    check("big err_count", 64'(b_err), 64'd0);
    check("errinst done cycle", 64'(e_done_cyc), 64'd8195);
    check("errinst err_count", 64'(e_err), 64'h2000);
    check("errinst init_error", 64'(e_error), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
